// File: rtl/d6809_bus_unit_if.sv
// rtl/d6809_bus_unit_if.sv - control-unit strobes, external byte bus and register outputs of the d6809 bus unit
interface d6809_bus_unit_if;
    logic [3:0]  mem_read;
    logic [15:0] fetch;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_din;
    logic [7:0]  DP;
    logic        bus_ack;
    logic [7:0]  bus_din;
    logic        bus_rd;
    logic [15:0] bus_addr;
    logic        stall;
    logic        bus_err;
    logic [15:0] PC;
    logic [15:0] AR;
    logic [15:0] IR;
    logic [7:0]  T;

    // Control unit / memory side: drives strobes and read data, observes the bus unit
    modport master (
        output mem_read, fetch, pc_inc, pc_load, pc_din, DP, bus_ack, bus_din,
        input  bus_rd, bus_addr, stall, bus_err, PC, AR, IR, T
    );

    // Bus unit side
    modport slave (
        input  mem_read, fetch, pc_inc, pc_load, pc_din, DP, bus_ack, bus_din,
        output bus_rd, bus_addr, stall, bus_err, PC, AR, IR, T
    );
endinterface

// File: rtl/d6809_bus_unit.sv
// rtl/d6809_bus_unit.sv - d6809 byte-fetch bus unit owning PC/AR/IR/T; optional timeout via D6809_BUS_TIMEOUT_EN
module d6809_bus_unit #(
    parameter logic [15:0] RESET_PC = 16'hFFFE,
    parameter int          TIMEOUT  = 16
) (
    input logic              clk,
    input logic              reset,
    d6809_bus_unit_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_BUS} state_t;

    localparam logic [3:0] MEMREAD_PC     = 4'd1;
    localparam logic [3:0] MEMREAD_AR     = 4'd2;
    localparam logic [3:0] MEMREAD_DP_ARL = 4'd3;

    state_t      state_q;
    logic [15:0] pc_q, ar_q, ir_q;
    logic [7:0]  t_q;
    logic [15:0] bus_addr_q;
    logic        bus_rd_q;
    logic [3:0]  fetch_q;
    logic        inc_q;

    logic        req_valid;
    logic [15:0] req_addr;
    logic        ack_hit;
    logic        to_hit;
    logic        done;
    logic [7:0]  fill_byte;
    logic        unused_fetch_hi;

    assign unused_fetch_hi = ^bus.fetch[15:4];

`ifdef D6809_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    logic [15:0] wait_q;
    logic        bus_err_q;
    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    // Request decode, address source select and transfer-completion detection
    always_comb begin
        req_valid = (state_q == ST_IDLE) &&
                    (bus.mem_read == MEMREAD_PC || bus.mem_read == MEMREAD_AR ||
                     bus.mem_read == MEMREAD_DP_ARL);
        case (bus.mem_read)
            MEMREAD_AR:     req_addr = ar_q;
            MEMREAD_DP_ARL: req_addr = {bus.DP, ar_q[7:0]};
            default:        req_addr = pc_q;
        endcase
        ack_hit = (state_q == ST_BUS) && bus.bus_ack;
`ifdef D6809_BUS_TIMEOUT_EN
        // A real ack in the limit cycle takes precedence over the timeout
        to_hit = (state_q == ST_BUS) && !bus.bus_ack && (wait_q == TIMEOUT_CNT);
`else
        to_hit = 1'b0;
`endif
        done      = ack_hit || to_hit;
        fill_byte = ack_hit ? bus.bus_din : 8'hFF;
        bus.stall = !reset && (req_valid || ((state_q == ST_BUS) && !done));
    end

    // FSM, held transfer context and the PC/AR/IR/T register file
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ar_q       <= 16'h0000;
            ir_q       <= 16'h0000;
            t_q        <= 8'h00;
            bus_addr_q <= 16'h0000;
            bus_rd_q   <= 1'b0;
            fetch_q    <= 4'h0;
            inc_q      <= 1'b0;
`ifdef D6809_BUS_TIMEOUT_EN
            wait_q     <= 16'h0000;
            bus_err_q  <= 1'b0;
`endif
        end else begin
`ifdef D6809_BUS_TIMEOUT_EN
            bus_err_q <= to_hit;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        bus_addr_q <= req_addr;
                        fetch_q    <= bus.fetch[3:0];
                        inc_q      <= bus.pc_inc;
                        bus_rd_q   <= 1'b1;
                        state_q    <= ST_BUS;
`ifdef D6809_BUS_TIMEOUT_EN
                        wait_q     <= 16'h0000;
`endif
                    end
                end
                ST_BUS: begin
                    if (done) begin
                        if (fetch_q[0]) ir_q       <= {8'h00, fill_byte};
                        if (fetch_q[1]) ar_q[15:8] <= fill_byte;
                        if (fetch_q[2]) ar_q[7:0]  <= fill_byte;
                        if (fetch_q[3]) t_q        <= fill_byte;
                        bus_rd_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
`ifdef D6809_BUS_TIMEOUT_EN
                        wait_q <= wait_q + 16'd1;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Execute-stage load beats any increment from either path
            if (bus.pc_load)
                pc_q <= bus.pc_din;
            else if ((done && inc_q) ||
                     ((state_q == ST_IDLE) && !req_valid && bus.pc_inc))
                pc_q <= pc_q + 16'd1;
        end
    end

    assign bus.bus_rd   = bus_rd_q;
    assign bus.bus_addr = bus_addr_q;
    assign bus.PC       = pc_q;
    assign bus.AR       = ar_q;
    assign bus.IR       = ir_q;
    assign bus.T        = t_q;

endmodule
